// File: rtl/alu_execute.sv
// alu_execute: sequential execute stage between the register file read and write ports.
//   Add, sub and logic ops take one EXEC cycle. Shifts move one bit per cycle. MUL is a
//   16-step shift-add. Each op ends in a single WB cycle that strobes one register port.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, op, dst_sel   request, opcode and write-back port select (sampled in IDLE only)
//   operand_a/_b         operands from register read ports 1/2
//   result, flags        registered write-back data and {N,Z,C,V}
//   write                one-hot write strobe, high only in WB
//   busy, done           not-IDLE / WB-cycle indicators
module alu_execute #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             dst_sel,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       write,
   output logic [3:0]       flags,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OpAdd = 3'd0;
   localparam logic [2:0] OpSub = 3'd1;
   localparam logic [2:0] OpAnd = 3'd2;
   localparam logic [2:0] OpOr  = 3'd3;
   localparam logic [2:0] OpXor = 3'd4;
   localparam logic [2:0] OpShl = 3'd5;
   localparam logic [2:0] OpShr = 3'd6;
   localparam logic [2:0] OpMul = 3'd7;

   typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

   state_e                 r_state, w_state_next;
   logic [WIDTH-1:0]       r_a, r_b;
   logic [2:0]             r_op;
   logic                   r_dst;
   logic [3:0]             r_cnt;
   logic [2*WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]       r_result;
   logic [3:0]             r_flags;

   logic [WIDTH:0]         w_sum, w_diff, w_mul_sum;
   logic [2*WIDTH-1:0]     w_acc_next;
   logic [WIDTH-1:0]       w_res;
   logic                   w_c, w_v, w_last;
   logic                   w_accept;

   assign w_accept = (r_state == StIdle) && start;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (start) w_state_next = StExec;
         StExec:  if (w_last) w_state_next = StWb;
         StWb:    w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs decoded from state; reset clears write/done/busy without waiting for a clock.
   always_comb begin
      busy  = (r_state != StIdle);
      done  = (r_state == StWb);
      write = 2'b00;
      if (r_state == StWb) write = r_dst ? 2'b10 : 2'b01;
   end

   assign result = r_result;
   assign flags  = r_flags;

   // Execute datapath: w_res/w_c/w_v are the values for this EXEC step, w_last marks the
   // step whose outcome is latched into result/flags.
   always_comb begin
      w_sum      = {1'b0, r_a} + {1'b0, r_b};
      w_diff     = {1'b0, r_a} - {1'b0, r_b};  // MSB is the borrow
      // Right-shifting accumulator: add A into the high half, then shift the whole thing.
      w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
      w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
      w_res      = '0;
      w_c        = 1'b0;
      w_v        = 1'b0;
      w_last     = 1'b1;
      unique case (r_op)
         OpAdd: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         OpSub: begin
            w_res = w_diff[WIDTH-1:0];
            w_c   = w_diff[WIDTH];
            w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
         end
         OpAnd: w_res = r_a & r_b;
         OpOr:  w_res = r_a | r_b;
         OpXor: w_res = r_a ^ r_b;
         OpShl: begin
            if (r_cnt == 4'd0) begin
               w_res = r_a;
            end else begin
               w_res  = {r_a[WIDTH-2:0], 1'b0};
               w_c    = r_a[WIDTH-1];
               w_last = (r_cnt == 4'd1);
            end
         end
         OpShr: begin
            if (r_cnt == 4'd0) begin
               w_res = r_a;
            end else begin
               w_res  = {1'b0, r_a[WIDTH-1:1]};
               w_c    = r_a[0];
               w_last = (r_cnt == 4'd1);
            end
         end
         OpMul: begin
            w_res  = w_acc_next[WIDTH-1:0];
            w_c    = |w_acc_next[2*WIDTH-1:WIDTH];
            w_last = (r_cnt == 4'(WIDTH - 1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_dst    <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_flags  <= '0;
      end else if (w_accept) begin
         r_a   <= operand_a;
         r_b   <= operand_b;
         r_op  <= op;
         r_dst <= dst_sel;
         r_acc <= '0;
         // Shifts count down from n; MUL counts up 0..WIDTH-1.
         r_cnt <= (op == OpShl || op == OpShr) ? operand_b[3:0] : 4'd0;
      end else if (r_state == StExec) begin
         if ((r_op == OpShl || r_op == OpShr) && r_cnt != 4'd0) begin
            r_a   <= w_res;
            r_cnt <= r_cnt - 4'd1;
         end
         if (r_op == OpMul) begin
            r_acc <= w_acc_next;
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_cnt <= r_cnt + 4'd1;
         end
         if (w_last) begin
            r_result <= w_res;
            r_flags  <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
         end
      end
   end

endmodule

// File: tb/tb_alu_execute.sv
// Directed bench for alu_execute: latency, write strobe, result and flags per op class,
// ignored start while busy, and asynchronous reset in the middle of a multiply.
module tb_alu_execute;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic        dst_sel;
   logic [15:0] operand_a, operand_b;
   logic [15:0] result;
   logic [1:0]  write;
   logic [3:0]  flags;
   logic        busy, done;

   int n_checks = 0;
   int n_errors = 0;

   alu_execute #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .dst_sel   (dst_sel),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .result    (result),
      .write     (write),
      .flags     (flags),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one op at edge k, then find the WB cycle (j means cycle k+j) and check it.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic d, input int exp_lat,
                         input logic [15:0] exp_res, input logic [3:0] exp_flags);
      int  lat;
      logic [1:0] wr;
      lat = 0;
      wr  = 2'b00;
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b; dst_sel = d;
      @(posedge clk);
      #1;
      start = 1'b0;
      operand_a = 16'($urandom);
      operand_b = 16'($urandom);
      for (int j = 1; j <= 40 && lat == 0; j++) begin
         @(negedge clk);
         if (done) begin
            lat = j;
            wr  = write;
         end
      end
      check({tag, "_lat"},    32'(lat), 32'(exp_lat));
      check({tag, "_write"},  32'(wr), d ? 32'h2 : 32'h1);
      check({tag, "_result"}, 32'(result), 32'(exp_res));
      check({tag, "_flags"},  32'(flags), 32'(exp_flags));
      @(negedge clk);
      check({tag, "_idle"},   32'({busy, write, done}), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int         wb_cnt, wb_at, busy_gap, wr_cnt;
      logic [15:0] wb_res;
      logic [1:0]  wb_wr;

      rst_n = 1'b0; start = 1'b0; op = 3'd0; dst_sel = 1'b0;
      operand_a = '0; operand_b = '0;
      #12;
      check("rst_outputs", 32'({result, flags, write, busy, done}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release", 32'({busy, write, done}), 32'h0);

      //     tag        op    a         b         dst  lat  result    NZCV
      run_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 1'b0, 2, 16'h8000, 4'b1001);
      run_op("add_cy",  3'd0, 16'hFFFF, 16'h0001, 1'b1, 2, 16'h0000, 4'b0110);
      run_op("sub_brw", 3'd1, 16'h0003, 16'h0005, 1'b1, 2, 16'hFFFE, 4'b1010);
      run_op("sub_z",   3'd1, 16'h1234, 16'h1234, 1'b0, 2, 16'h0000, 4'b0100);
      run_op("and",     3'd2, 16'hF0F0, 16'h0FF0, 1'b0, 2, 16'h00F0, 4'b0000);
      run_op("or",      3'd3, 16'h8000, 16'h0001, 1'b1, 2, 16'h8001, 4'b1000);
      run_op("xor",     3'd4, 16'hAAAA, 16'hAAAA, 1'b0, 2, 16'h0000, 4'b0100);
      run_op("shl1",    3'd5, 16'h8001, 16'h0001, 1'b0, 2, 16'h0002, 4'b0010);
      run_op("shl4",    3'd5, 16'hF000, 16'hFFF4, 1'b1, 5, 16'h0000, 4'b0110);
      run_op("shr15",   3'd6, 16'h8000, 16'h000F, 1'b0, 16, 16'h0001, 4'b0000);
      run_op("shr0",    3'd6, 16'h9234, 16'h0000, 1'b1, 2, 16'h9234, 4'b1000);
      run_op("mul",     3'd7, 16'h0123, 16'h0010, 1'b0, 17, 16'h1230, 4'b0000);
      run_op("mul_hi",  3'd7, 16'h1000, 16'h0010, 1'b1, 17, 16'h0000, 4'b0110);
      run_op("mul_ff",  3'd7, 16'hFFFF, 16'hFFFF, 1'b0, 17, 16'h0001, 4'b0010);

      // Start pulse at k+5 during a MUL must be ignored.
      @(negedge clk);
      start = 1'b1; op = 3'd7; operand_a = 16'h0003; operand_b = 16'h0005; dst_sel = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wb_cnt = 0; wb_at = 0; busy_gap = 0; wb_res = '0; wb_wr = '0;
      for (int j = 1; j <= 22; j++) begin
         @(negedge clk);
         if (j == 5) begin
            start = 1'b1; op = 3'd0; operand_a = 16'h1111; operand_b = 16'h2222;
         end
         if (j == 6) start = 1'b0;
         if (done) begin
            wb_cnt++;
            wb_at  = j;
            wb_res = result;
            wb_wr  = write;
         end
         if (j <= 17 && !busy) busy_gap++;
      end
      check("ign_wb_count", 32'(wb_cnt), 32'd1);
      check("ign_wb_at",    32'(wb_at), 32'd17);
      check("ign_result",   32'(wb_res), 32'h000F);
      check("ign_write",    32'(wb_wr), 32'h2);
      check("ign_busy_gap", 32'(busy_gap), 32'd0);
      check("ign_idle",     32'(busy), 32'd0);

      // Reset at k+8 of a MUL; leave non-zero result/flags behind first.
      run_op("sub_pre", 3'd1, 16'h0003, 16'h0005, 1'b0, 2, 16'hFFFE, 4'b1010);
      @(negedge clk);
      start = 1'b1; op = 3'd7; operand_a = 16'h0123; operand_b = 16'h0010; dst_sel = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int j = 1; j <= 8; j++) @(negedge clk);
      check("rmid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rmid_ctrl",   32'({busy, write, done}), 32'h0);
      check("rmid_result", 32'(result), 32'h0);
      check("rmid_flags",  32'(flags), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wr_cnt = 0;
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         if (done || write != 2'b00 || busy) wr_cnt++;
      end
      check("rmid_no_write", 32'(wr_cnt), 32'd0);
      run_op("add_post", 3'd0, 16'h0001, 16'h0002, 1'b1, 2, 16'h0003, 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_execute.md
# alu_execute

Sequential execute stage that consumes the two operand read ports of the 4×16-bit register file and produces the write-back word and one-hot write strobe for it. Add, subtract and logic ops complete in one execute cycle. Shifts iterate one bit per cycle, and multiply is a 16-cycle shift-add. The sequencer issues a start pulse with opcode and destination select, then waits for `done`.

## Interface
Parameters:
- `WIDTH`, 16, datapath width; only 16 is supported.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only in IDLE.
- `op`  in  3  opcode:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SHL by `operand_b[3:0]`, 6 SHR logical by `operand_b[3:0]`
  - 7 MUL, low 16 bits of the product
- `dst_sel`  in  1  write-back target: 0 selects port 1 (`write`=01), 1 selects port 2 (`write`=10).
- `operand_a`  in  16  first operand, driven from register read port 1.
- `operand_b`  in  16  second operand, driven from register read port 2.
- `result`  out  16  registered write-back data, driving the register file input bus.
- `write`  out  2  one-hot write strobe to the register file; high for exactly one cycle.
- `flags`  out  4  {N,Z,C,V}, registered.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  high in the WB cycle; coincides with `write`.

## Operation
- Three states: IDLE, EXEC, WB.
- **IDLE**
  - `start`=1 at a rising edge latches `operand_a`, `operand_b`, `op` and `dst_sel`, then moves to EXEC.
  - The register read ports are valid only while `write`=00. IDLE guarantees this, so operands are never sampled at any other time.
- **EXEC**
  - Ops 0–4: compute once, go to WB next edge (EXEC lasts 1 cycle).
  - SHL/SHR, with n = `b[3:0]`:
    - n=0: EXEC lasts 1 cycle, result = A, C=0.
    - Otherwise: shift one bit per cycle for n cycles; C = last bit shifted out.
  - MUL: 16 iterations of shift-add over `b` LSB-first into a 32-bit accumulator, so EXEC lasts 16 cycles.
    - result = product[15:0].
    - C = 1 if product[31:16] ≠ 0.
- **WB**
  - `result` and `flags` update on entry to WB.
  - `write[dst_sel]`=1 and `done`=1 for this one cycle, then return to IDLE.
- Flags, latched only on entry to WB:
  - N = result[15]; Z = (result == 0).
  - ADD: C = carry out; V = signed overflow.
  - SUB (A−B): C = borrow (A < B unsigned); V = signed overflow.
  - AND/OR/XOR: C = 0, V = 0.
  - Shifts and MUL: V = 0.
- `result` and `flags` hold their value between WB cycles.
- `start` while `busy`=1 (EXEC or WB) is ignored: no queuing, no effect on the current op.
- Reset:
  - All outputs go to 0 and the state to IDLE.
  - Asserting reset during EXEC or WB aborts the op immediately; `write` drops asynchronously and no write-back occurs.
  - After reset deassertion, the first accepted start behaves normally.

## Timing
- Rising edge k samples `start`=1 in IDLE → `busy`=1 from cycle k+1.
- WB cycle, where `write`/`done` are high, by op class:
  - Ops 0–4: cycle k+2.
  - Shift by n: cycle k+1+max(n,1).
  - MUL: cycle k+17.
- The register file captures `result` at the rising edge that ends the WB cycle.
- `busy` falls the cycle after WB. The earliest next `start` is sampled at the edge ending WB+1, i.e. in IDLE.
- Back-to-back ADDs issue every 3 cycles.
- `write` is never asserted outside WB; at most one bit of `write` is ever set.

## Test plan
- **ADD**: `op`=0, a=0x7FFF, b=0x0001, `dst_sel`=0.
  - WB at k+2 with `write`=01, `result`=0x8000, flags N=1 Z=0 C=0 V=1.
- **SUB**: `op`=1, a=0x0003, b=0x0005, `dst_sel`=1.
  - `write`=10, `result`=0xFFFE, N=1 C=1 V=0.
  - Then a=b=0x1234 gives `result`=0x0000, Z=1, C=0.
- **Shifts**:
  - SHL a=0x8001, b=0x0001 → WB at k+2, `result`=0x0002, C=1.
  - SHR a=0x8000, b=0x000F → WB at k+16, `result`=0x0001, C=0.
  - SHR with b=0 → WB at k+2, `result`=a.
- **MUL**:
  - a=0x0123, b=0x0010 → WB at k+17, `result`=0x1230, C=0.
  - a=0x1000, b=0x0010 → `result`=0x0000, Z=1, C=1.
- **Ignored start**: pulse `start` with `op`=0 at k+5 during a MUL.
  - Exactly one WB occurs, at k+17, carrying the MUL result.
  - `busy` is continuous from k+1 to k+17.
- **Reset mid-op**: assert `rst_n`=0 at k+8 of a MUL.
  - `busy`, `write`, `done`, `result` and `flags` are 0 immediately.
  - No write occurs; a following ADD completes at its own k'+2.
